mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory port: a load/store unit in the MEM stage.
- Accepts one load/store request at a time from the pipeline over a valid/ready handshake.
- Drives the word-addressed memory interface: MemWrite, MemRead, Address, WriteData, and combinational read Data.
- Performs byte and halfword accesses: extract plus sign/zero-extend on loads, read-modify-write on stores, because the memory only stores whole words.

Parameters:
- MEM_WORDS, 32: memory depth in words; word index >= MEM_WORDS is an error.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (IDLE state and rst low)
- req_write  input  1  1=store, 0=load
- req_size  input  2  00=byte, 01=half, 10=word, 11=illegal
- req_unsigned  input  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  input  32  byte address, little-endian
- req_wdata  input  32  store data; sub-word data in low bits
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  load result; 0 for stores and errors
- resp_err  output  1  valid with resp_valid: misaligned, illegal size or out of range
- MemWrite  output  1  memory write strobe, sampled by memory at posedge clk
- MemRead  output  1  memory read enable
- Address  output  32  word index = {2'b00, req_addr[31:2]} of latched request
- WriteData  output  32  full word to write
- Data  input  32  memory read data, combinational from Address/MemRead

Behaviour:
- Reset: async, active-high; state=IDLE; all outputs 0, including req_ready; latched request and result registers 0.
- Handshake: a request is accepted on the rising edge where req_valid&req_ready. All request fields are latched at acceptance, and the inputs are ignored afterwards.
- Memory outputs are decoded from the state register and latched fields only; there is no combinational path from req_* to the memory outputs.
- States:
  - IDLE: req_ready=1. On accept: if error, go RESP with err flag set. Else load -> RD; word store -> WR; sub-word store -> RMW.
  - RD: MemRead=1, Address=word index. At the edge, capture the extracted result; go RESP.
  - RMW: MemRead=1. At the edge, merge the new byte/half into the captured Data word; go WR.
  - WR: MemWrite=1, WriteData = merged word (sub-word) or req_wdata (word); go RESP.
  - RESP: resp_valid=1 for exactly one cycle, with resp_rdata and resp_err; go IDLE. req_ready=0 in this state.
- Error conditions (checked at accept):
  - req_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - req_addr[31:2] >= MEM_WORDS.
  - On error: no MemRead/MemWrite is ever asserted; resp_rdata=0.
- Load extraction:
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane];
  - half lane = addr[1], bits [16*h+15 : 16*h];
  - extend to 32 bits per req_unsigned.
- Store merge: replace only the addressed lane with req_wdata[7:0] or req_wdata[15:0]; all other bits come from the read word.
- Latency, from accept edge to the cycle resp_valid is high:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Throughput: no overlap. The next request can be accepted only on the edge ending IDLE, i.e. at least one cycle after RESP.
- Reset mid-operation: the access is aborted. MemWrite/MemRead drop immediately with rst, no resp_valid is produced, and the unit restarts in IDLE.

Optional Feature:
- LSU_SUBWORD_EN
  - Defined: byte/half accesses supported as above, including the RMW state.
  - Undefined: RMW state and lane logic are not built. Any req_size other than 10 is an error (1-cycle error response, no memory access). Word behaviour is unchanged.

Test Plan:
- Memory preloaded Mem[2]=11; load word at 0x08 -> MemRead high exactly 1 cycle with Address=2; resp_valid 2 cycles after accept; resp_rdata=0x0000000B, resp_err=0.
- Store word 0x12345680 at 0x0C (MemWrite 1 cycle, Address=3), then:
  - load byte signed at 0x0C -> 0xFFFFFF80;
  - load byte unsigned at 0x0C -> 0x00000080;
  - load half signed at 0x0E -> 0x00001234.
- Store byte 0xAB at 0x0D -> MemRead 1 cycle, then MemWrite 1 cycle with WriteData=0x1234AB80; resp_valid 3 cycles after accept; later word load at 0x0C returns 0x1234AB80.
- Error cases, each giving resp_err=1 and resp_rdata=0 one cycle after accept, with MemRead/MemWrite never high:
  - load word at 0x06;
  - load at 0x80 (index 32);
  - req_size=11.
- req_valid held high across two requests -> req_ready low from accept until after RESP; second request accepted only in the cycle after resp_valid; both responses correct and in order.
- Assert rst while in WR state -> MemWrite falls in the same cycle, no resp_valid; after release req_ready=1 and a word load at 0x04 returns 0x00000001.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage load/store initiator for a word-addressed data memory.
//            Byte/halfword support (RMW stores, extending loads) is built only
//            when LSU_SUBWORD_EN is defined; otherwise only word accesses are legal.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemWrite,
    output logic        MemRead,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] Data
);

    localparam logic [1:0] c_size_byte = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_word = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_RESP = 3'd3
`ifdef LSU_SUBWORD_EN
        , S_RMW = 3'd4
`endif
    } state_t;

    state_t      r_state;
    logic [29:0] r_index;
    logic [31:0] r_wdata;
    logic [31:0] r_result;
    logic        r_err;
    logic        w_range_err;
    logic        w_req_err;
    logic [31:0] w_load;

    assign w_range_err = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);

`ifdef LSU_SUBWORD_EN
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_unsigned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_merged;

    always_comb begin
        w_req_err = w_range_err;
        case (req_size)
            c_size_byte: ;
            c_size_half: if (req_addr[0]) w_req_err = 1'b1;
            c_size_word: if (req_addr[1:0] != 2'b00) w_req_err = 1'b1;
            default:     w_req_err = 1'b1;
        endcase
    end

    // Lane extraction for loads and lane replacement for read-modify-write stores.
    always_comb begin
        w_byte   = Data[{r_lane, 3'b000} +: 8];
        w_half   = Data[{r_lane[1], 4'b0000} +: 16];
        case (r_size)
            c_size_byte: w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            c_size_half: w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            default:     w_load = Data;
        endcase
        w_merged = Data;
        if (r_size == c_size_byte)
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        else
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
    end

    assign MemRead = (r_state == S_RD) || (r_state == S_RMW);
`else
    logic w_unused;

    assign w_unused  = req_unsigned;
    assign w_req_err = w_range_err || (req_size != c_size_word) || (req_addr[1:0] != 2'b00);
    assign w_load    = Data;
    assign MemRead   = (r_state == S_RD);
`endif

    assign req_ready  = (r_state == S_IDLE) && !rst;
    assign MemWrite   = (r_state == S_WR);
    assign Address    = {2'b00, r_index};
    assign WriteData  = r_wdata;
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = resp_valid ? r_result : 32'h0;
    assign resp_err   = resp_valid & r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_index    <= '0;
            r_wdata    <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
`ifdef LSU_SUBWORD_EN
            r_size     <= '0;
            r_lane     <= '0;
            r_unsigned <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_index    <= req_addr[31:2];
                        r_wdata    <= req_wdata;
                        r_result   <= '0;
                        r_err      <= w_req_err;
`ifdef LSU_SUBWORD_EN
                        r_size     <= req_size;
                        r_lane     <= req_addr[1:0];
                        r_unsigned <= req_unsigned;
`endif
                        if (w_req_err)
                            r_state <= S_RESP;
                        else if (!req_write)
                            r_state <= S_RD;
`ifdef LSU_SUBWORD_EN
                        else if (req_size != c_size_word)
                            r_state <= S_RMW;
`endif
                        else
                            r_state <= S_WR;
                    end
                end
                S_RD: begin
                    r_result <= w_load;
                    r_state  <= S_RESP;
                end
`ifdef LSU_SUBWORD_EN
                // The merged word replaces the store data so WR always drives r_wdata.
                S_RMW: begin
                    r_wdata <= w_merged;
                    r_state <= S_WR;
                end
`endif
                S_WR:    r_state <= S_RESP;
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed table-driven bench for mem_access_unit with a word memory
//            model; expectations follow LSU_SUBWORD_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

`ifdef LSU_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] Data;

    logic [31:0] mem [0:31];
    int tests = 0;
    int fails = 0;

    mem_access_unit #(.MEM_WORDS(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemWrite(MemWrite), .MemRead(MemRead), .Address(Address),
        .WriteData(WriteData), .Data(Data)
    );

    always #5 clk = ~clk;

    assign Data = (MemRead && Address < 32) ? mem[Address[4:0]] : 32'h0;

    always @(posedge clk)
        if (MemWrite && Address < 32) mem[Address[4:0]] <= WriteData;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err, input int lat,
                                input int nrd, input int nwr, input logic [31:0] ewd);
        vec_t v;
        v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = rdata; v.exp_err = err; v.lat = lat; v.nrd = nrd; v.nwr = nwr;
        v.exp_wdata = ewd;
        return v;
    endfunction

    function automatic vec_t as_err(input vec_t v);
        vec_t e = v;
        e.exp_rdata = 32'h0; e.exp_err = 1'b1; e.lat = 1; e.nrd = 0; e.nwr = 0;
        return e;
    endfunction

    // Sub-word vectors turn into 1-cycle error responses in a word-only build.
    function automatic vec_t sw(input vec_t v);
        return SUBWORD ? v : as_err(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_req(input int idx, input vec_t v);
        int          lat = 0;
        int          nr = 0;
        int          nw = 0;
        logic        addr_ok = 1'b1;
        logic [31:0] seen_wd = '0;
        @(negedge clk);
        req_write = v.wr; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        chk($sformatf("v%0d ready", idx), {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = 32'hFFFF_FFFF; req_wdata = ~v.wdata; req_size = ~v.size; req_unsigned = ~v.uns;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (MemRead) nr++;
            if (MemWrite) begin nw++; seen_wd = WriteData; end
            if ((MemRead || MemWrite) && Address != {2'b00, v.addr[31:2]}) addr_ok = 1'b0;
            if (resp_valid) begin lat = k; break; end
        end
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d rdata", idx), resp_rdata, v.exp_rdata);
        chk($sformatf("v%0d err", idx), {31'b0, resp_err}, {31'b0, v.exp_err});
        chk($sformatf("v%0d reads", idx), nr, v.nrd);
        chk($sformatf("v%0d writes", idx), nw, v.nwr);
        chk($sformatf("v%0d address", idx), {31'b0, addr_ok}, 32'd1);
        if (v.nwr > 0) chk($sformatf("v%0d wdata", idx), seen_wd, v.exp_wdata);
        @(negedge clk);
        chk($sformatf("v%0d resp one cycle", idx), {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin : main
        int   first;
        int   second;
        logic rdy_bad;
        logic resp_seen;

        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[1]  = 32'h0000_0001;
        mem[2]  = 32'h0000_000B;
        mem[31] = 32'hCAFE_F00D;

        //             wr    size  uns   addr   wdata          rdata                             err  lat rd wr exp_wdata
        vecs[0]  =    mk(1'b0, 2'b10, 1'b0, 32'h08, 32'h0,         32'h0000_000B,                    1'b0, 2, 1, 0, 32'h0);
        vecs[1]  =    mk(1'b1, 2'b10, 1'b0, 32'h0C, 32'h1234_5680, 32'h0,                            1'b0, 2, 0, 1, 32'h1234_5680);
        vecs[2]  = sw(mk(1'b0, 2'b00, 1'b0, 32'h0C, 32'h0,         32'hFFFF_FF80,                    1'b0, 2, 1, 0, 32'h0));
        vecs[3]  = sw(mk(1'b0, 2'b00, 1'b1, 32'h0C, 32'h0,         32'h0000_0080,                    1'b0, 2, 1, 0, 32'h0));
        vecs[4]  = sw(mk(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0,         32'h0000_1234,                    1'b0, 2, 1, 0, 32'h0));
        vecs[5]  = sw(mk(1'b1, 2'b00, 1'b0, 32'h0D, 32'hFFFF_FFAB, 32'h0,                            1'b0, 3, 1, 1, 32'h1234_AB80));
        vecs[6]  =    mk(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0,
                         SUBWORD ? 32'h1234_AB80 : 32'h1234_5680,                                    1'b0, 2, 1, 0, 32'h0);
        vecs[7]  = sw(mk(1'b0, 2'b01, 1'b0, 32'h0C, 32'h0,         32'hFFFF_AB80,                    1'b0, 2, 1, 0, 32'h0));
        vecs[8]  = sw(mk(1'b1, 2'b01, 1'b0, 32'h0E, 32'h5555_BEEF, 32'h0,                            1'b0, 3, 1, 1, 32'hBEEF_AB80));
        vecs[9]  = sw(mk(1'b0, 2'b00, 1'b1, 32'h0F, 32'h0,         32'h0000_00BE,                    1'b0, 2, 1, 0, 32'h0));
        vecs[10] =    mk(1'b0, 2'b10, 1'b0, 32'h06, 32'h0,         32'h0,                            1'b1, 1, 0, 0, 32'h0);
        vecs[11] =    mk(1'b0, 2'b10, 1'b0, 32'h80, 32'h0,         32'h0,                            1'b1, 1, 0, 0, 32'h0);
        vecs[12] =    mk(1'b0, 2'b11, 1'b0, 32'h00, 32'h0,         32'h0,                            1'b1, 1, 0, 0, 32'h0);
        vecs[13] =    mk(1'b0, 2'b01, 1'b0, 32'h01, 32'h0,         32'h0,                            1'b1, 1, 0, 0, 32'h0);
        vecs[14] =    mk(1'b1, 2'b10, 1'b0, 32'h80, 32'h7777_7777, 32'h0,                            1'b1, 1, 0, 0, 32'h0);
        vecs[15] =    mk(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0,         32'hCAFE_F00D,                    1'b0, 2, 1, 0, 32'h0);

        #12;
        chk("reset ready", {31'b0, req_ready}, 32'd0);
        chk("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("reset mem strobes", {30'b0, MemRead, MemWrite}, 32'd0);
        chk("reset Address", Address, 32'd0);
        chk("reset WriteData", WriteData, 32'd0);
        chk("reset rdata/err", {resp_rdata[30:0], resp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_req(i, vecs[i]);

        // Back-to-back: req_valid stays high across two loads.
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h08; req_valid = 1'b1;
        chk("b2b ready idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_addr = 32'h04;
        first = 0; second = 0; rdy_bad = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (resp_valid && first == 0) begin
                first = k;
                chk("b2b rdata1", resp_rdata, 32'h0000_000B);
            end else if (resp_valid) begin
                second = k;
                chk("b2b rdata2", resp_rdata, 32'h0000_0001);
            end
            if (k == 3) begin
                chk("b2b ready after resp", {31'b0, req_ready}, 32'd1);
                @(posedge clk);
                #1;
                req_valid = 1'b0;
            end else if (k != 6 && req_ready) begin
                rdy_bad = 1'b1;
            end
        end
        chk("b2b ready low while busy", {31'b0, rdy_bad}, 32'd0);
        chk("b2b first resp cycle", first, 32'd2);
        chk("b2b second resp cycle", second, 32'd5);

        // Reset while the WR state is driving MemWrite.
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b10; req_addr = 32'h04;
        req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst-mid MemWrite before", {31'b0, MemWrite}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst-mid MemWrite drops", {31'b0, MemWrite}, 32'd0);
        chk("rst-mid ready low", {31'b0, req_ready}, 32'd0);
        resp_seen = 1'b0;
        @(negedge clk);
        if (resp_valid) resp_seen = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (resp_valid) resp_seen = 1'b1;
        end
        chk("rst-mid no resp", {31'b0, resp_seen}, 32'd0);
        chk("rst-mid ready after", {31'b0, req_ready}, 32'd1);
        run_req(100, mk(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h0000_0001, 1'b0, 2, 1, 0, 32'h0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
